// File: rtl/prim_util_pkg.sv
// Shared elaboration-time helpers for sizing vectors from parameters.
package prim_util_pkg;

    // Bits needed to index `value` items; never less than one.
    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/spi_host_cmd_arb_pkg.sv
// Types and sizing helpers shared by the SPI host command arbiter.
package spi_host_cmd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        BUSY   = 2'd2,
        LOCKED = 2'd3
    } arb_state_e;

    // Lock watchdog counter width for a given cycle limit.
    function automatic int tmo_cnt_w(input int timeout_cycles);
        return prim_util_pkg::vbits(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/spi_host_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module spi_host_rr_pick #(
    parameter int N    = 4,
    parameter int IdxW = prim_util_pkg::vbits(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    logic [N-1:0] rot;
    logic [IdxW:0] sum;

    // rot[i] holds req[(ptr + i) mod N]
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        idx = '0;
        any = 1'b0;
        sum = '0;
        // Descending scan so the smallest offset from ptr is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (IdxW + 1)'(i);
                if (sum >= (IdxW + 1)'(N)) begin
                    sum = sum - (IdxW + 1)'(N);
                end
                idx = sum[IdxW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_host_cmd_arb.sv
// Arbitrates N command requesters onto one SPI host command port, with CS-hold locking.
// Latency: first cmd_valid_o one cycle after req_valid_i; optional lock watchdog via SPI_HOST_CMD_ARB_TIMEOUT_EN.
// Backpressure: command held in ISSUE until cmd_ready_i; req_ready_o pulses only on that acceptance.
module spi_host_cmd_arb
    import spi_host_cmd_arb_pkg::*;
#(
    parameter int N             = 4,
    parameter int CmdW          = 16,
    parameter int TimeoutCycles = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N-1:0]                       req_valid_i,
    output logic [N-1:0]                       req_ready_o,
    input  logic [N*CmdW-1:0]                  req_cmd_i,
    input  logic [N-1:0]                       req_csaat_i,
    output logic                               cmd_valid_o,
    input  logic                               cmd_ready_i,
    output logic [CmdW-1:0]                    cmd_o,
    output logic                               cmd_csaat_o,
    input  logic                               done_i,
    output logic [prim_util_pkg::vbits(N)-1:0] grant_idx_o,
    output logic                               busy_o,
    output logic                               timeout_o
);

    localparam int IdxW = prim_util_pkg::vbits(N);

    arb_state_e     state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] next_ptr;
    logic [CmdW-1:0] cmd_q, cmd_d;
    logic            csaat_q, csaat_d;
    logic [IdxW-1:0] pick_idx;
    logic            pick_any;
    logic [CmdW-1:0] cmd_arr [N];

    for (genvar k = 0; k < N; k++) begin : g_cmd_split
        assign cmd_arr[k] = req_cmd_i[k*CmdW +: CmdW];
    end

    spi_host_rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .req (req_valid_i),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign next_ptr = (grant_q == IdxW'(N - 1)) ? '0 : grant_q + IdxW'(1);

`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
    localparam int TW = tmo_cnt_w(TimeoutCycles);
    logic [TW-1:0] wdog_q, wdog_d;
    logic          tmo_fire;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TimeoutCycles;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cmd_d       = cmd_q;
        csaat_d     = csaat_q;
        req_ready_o = '0;
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
        wdog_d      = wdog_q;
        tmo_fire    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cmd_d   = cmd_arr[pick_idx];
                    csaat_d = req_csaat_i[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // done_i is deliberately not looked at here.
                if (cmd_ready_i && !rst_i) begin
                    req_ready_o = N'(1) << grant_q;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (done_i) begin
                    if (csaat_q) begin
                        state_d = LOCKED;
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
                        wdog_d  = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        ptr_d   = next_ptr;
                    end
                end
            end
            LOCKED: begin
                // Only the owner may continue a CS-held transaction.
                if (req_valid_i[grant_q]) begin
                    cmd_d   = cmd_arr[grant_q];
                    csaat_d = req_csaat_i[grant_q];
                    state_d = ISSUE;
                end
`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
                else if (wdog_q == TW'(TimeoutCycles - 1)) begin
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                    ptr_d    = next_ptr;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cmd_q   <= '0;
            csaat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            csaat_q <= csaat_d;
        end
    end

`ifdef SPI_HOST_CMD_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
    assign timeout_o = tmo_fire;
`else
    assign timeout_o = 1'b0;
`endif

    assign cmd_valid_o = (state_q == ISSUE);
    assign cmd_o       = cmd_q;
    assign cmd_csaat_o = csaat_q;
    assign grant_idx_o = grant_q;
    assign busy_o      = (state_q != IDLE);

endmodule
